// File: rtl/divu_iter.sv
// divu_iter: multi-cycle iterative restoring divider, one quotient bit per clock.
// Shares the start/busy handshake of the iterative multiplier; the HI/LO writer
// takes q/r when done pulses.
//
// Optional feature: define DIVU_SIGNED_EN to add the 'sign' port and
// two's-complement DIV support (magnitude divide plus output sign correction).
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous, active-low
//   start  in   1      launch division; a/b (and sign) sampled on this edge
//   sign   in   1      (DIVU_SIGNED_EN only) 1 = signed DIV
//   a      in   WIDTH  dividend
//   b      in   WIDTH  divisor
//   q      out  WIDTH  quotient, valid from done until next start/reset
//   r      out  WIDTH  remainder, same validity as q
//   busy   out  1      high while iterating
//   done   out  1      one-cycle pulse when results first become valid
//   dbz    out  1      divide-by-zero flag, valid with q/r
module divu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef DIVU_SIGNED_EN
  input  logic             sign,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] qsh;
  logic [WIDTH:0]   rem;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] qsh_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] a_load;
  logic [WIDTH-1:0] b_load;
  logic             b_zero;

  assign b_zero = (b == '0);

  // One restoring step: shift {rem,qsh} left, trial-subtract the divisor.
  // rem < divisor holds between steps, so diff always fits in WIDTH+1 bits
  // and its MSB is a reliable sign.
  always_comb begin
    {rem_sh, qsh_sh} = {rem, qsh} << 1;
    diff             = rem_sh - {1'b0, divisor};
  end

`ifdef DIVU_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic neg_q_load;
  logic neg_r_load;

  // Operands become magnitudes on start; divide-by-zero keeps raw a so r==a.
  always_comb begin
    a_load     = a;
    b_load     = b;
    neg_q_load = 1'b0;
    neg_r_load = 1'b0;
    if (sign && !b_zero) begin
      if (a[WIDTH-1]) a_load = WIDTH'(0) - a;
      if (b[WIDTH-1]) b_load = WIDTH'(0) - b;
      neg_q_load = a[WIDTH-1] ^ b[WIDTH-1];
      neg_r_load = a[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      neg_q <= neg_q_load;
      neg_r <= neg_r_load;
    end
  end

  // Sign correction: quotient negated when signs differ, remainder follows dividend.
  assign q = neg_q ? (WIDTH'(0) - qsh) : qsh;
  assign r = neg_r ? (WIDTH'(0) - rem[WIDTH-1:0]) : rem[WIDTH-1:0];
`else
  assign a_load = a;
  assign b_load = b;
  assign q      = qsh;
  assign r      = rem[WIDTH-1:0];
`endif

  // Control and datapath registers; start restarts from any state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      divisor <= '0;
      qsh     <= '0;
      rem     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dbz     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state   <= RUN;
        divisor <= b_load;
        qsh     <= a_load;
        rem     <= '0;
        cnt     <= CNT_W'(1);
        busy    <= 1'b1;
        dbz     <= b_zero;
      end else if (state == RUN) begin
        cnt <= cnt + CNT_W'(1);
        if (diff[WIDTH]) begin
          rem <= rem_sh;
          qsh <= qsh_sh;
        end else begin
          rem <= diff;
          qsh <= qsh_sh | WIDTH'(1);
        end
        if (cnt == CNT_W'(WIDTH)) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_divu_iter.sv
// tb_divu_iter: directed bench for divu_iter with a result scoreboard.
// Expected q/r/dbz are pushed when an operation is launched and popped when
// done pulses. Define DIVU_SIGNED_EN for the signed cases as well.
module tb_divu_iter;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;
  logic        dbz;

  exp_t sb[$];
  int   n_tests;
  int   n_fail;

  divu_iter #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
`ifdef DIVU_SIGNED_EN
    .sign  (sign),
`endif
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // Reference model: plain unsigned divide, or magnitude divide with sign fix-up.
  function automatic exp_t model(input logic [31:0] aa, input logic [31:0] bb,
                                 input logic sg);
    exp_t        e;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] qm;
    logic [31:0] rm;
    if (bb == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = aa; e.dbz = 1'b1;
    end else if (!sg) begin
      e.q = aa / bb; e.r = aa % bb; e.dbz = 1'b0;
    end else begin
      ma = aa[31] ? (32'd0 - aa) : aa;
      mb = bb[31] ? (32'd0 - bb) : bb;
      qm = ma / mb;
      rm = ma % mb;
      e.q = (aa[31] ^ bb[31]) ? (32'd0 - qm) : qm;
      e.r = aa[31] ? (32'd0 - rm) : rm;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drives start for one edge, returns at the next negedge.
  task automatic launch(input logic [31:0] aa, input logic [31:0] bb,
                        input logic sg, input bit keep);
    a = aa; b = bb; sign = sg; start = 1'b1;
    if (keep) sb.push_back(model(aa, bb, sg));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge right after the start edge; returns in the done cycle.
  task automatic wait_result(input string tag);
    int   cyc;
    exp_t e;
    cyc = 0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd32);
    chk({tag, "_sb"}, 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_q"}, q, e.q);
      chk({tag, "_r"}, r, e.r);
      chk({tag, "_dbz"}, 32'(dbz), 32'(e.dbz));
      chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int pulses;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0; start = 1'b0; sign = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // T1: basic divide, then results hold in idle
    launch(32'd100, 32'd7, 1'b0, 1'b1);
    wait_result("t1");
    repeat (5) @(negedge clk);
    chk("t1_hold_q", q, 32'd14);
    chk("t1_hold_r", r, 32'd2);
    chk("t1_hold_done", 32'(done), 32'd0);

    // T2: extremes, second op launched in the done cycle of the first
    @(negedge clk);
    launch(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    wait_result("t2a");
    launch(32'd5, 32'hFFFF_FFFF, 1'b0, 1'b1);
    chk("t2_done_clr", 32'(done), 32'd0);
    wait_result("t2b");
    @(negedge clk);
    chk("t2_single_pulse", 32'(done), 32'd0);

    // T3: divide by zero
    launch(32'd1234, 32'd0, 1'b0, 1'b1);
    wait_result("t3");

    // T4: restart while busy at cnt==10
    @(negedge clk);
    launch(32'd100, 32'd7, 1'b0, 1'b0);
    pulses = 0;
    repeat (9) begin
      @(negedge clk);
      pulses += int'(done);
    end
    launch(32'd81, 32'd9, 1'b0, 1'b1);
    wait_result("t4");
    repeat (35) begin
      @(negedge clk);
      pulses += int'(done);
    end
    chk("t4_extra_pulses", 32'(pulses), 32'd0);

    // T5: reset aborts at cnt==20
    launch(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (19) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_q", q, 32'd0);
    chk("t5_r", r, 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    reset = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      pulses += int'(done);
    end
    chk("t5_no_done", 32'(pulses), 32'd0);
    launch(32'd9, 32'd4, 1'b0, 1'b1);
    wait_result("t5b");

    // Random unsigned operands
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      launch($urandom, (i < 2) ? 32'($urandom_range(1, 1000)) : $urandom, 1'b0, 1'b1);
      wait_result("rnd");
    end

`ifdef DIVU_SIGNED_EN
    // T6: signed division
    @(negedge clk);
    launch(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    wait_result("t6a");
    @(negedge clk);
    launch(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);
    wait_result("t6b");
    @(negedge clk);
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_result("t6c");
    @(negedge clk);
    launch(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1);
    wait_result("t6d");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
